la_stream_decoder: RTL and testbench



---
 rtl/la_stream_decoder.sv | 101 ++++++++++
 tb/tb_la_stream_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_stream_decoder.sv
// Logic-analyzer AXI-Stream receiver: expands {repeat, sample} run-length words
// into one sample per cycle on a valid/ready port, with word/sample counters and tag checking.
module la_stream_decoder #(
  parameter int         pDATA_WIDTH = 32,
  parameter int         pLA_WIDTH   = 24,
  parameter int         pCNT_WIDTH  = 8,
  parameter logic [1:0] pLA_TUSER   = 2'b10
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   la_enable,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic [3:0]             s_tstrb,
  input  logic [3:0]             s_tkeep,
  input  logic                   s_tlast,
  input  logic [1:0]             s_tuser,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [pLA_WIDTH-1:0]   la_data,
  output logic                   la_last,
  output logic                   la_valid,
  input  logic                   la_ready,
  output logic [15:0]            word_cnt,
  output logic [31:0]            sample_cnt,
  output logic                   tag_err
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t                 state, state_nxt;
  logic [pCNT_WIDTH-1:0]  rem, rem_nxt;
  logic [pLA_WIDTH-1:0]   data_nxt;
  logic                   tlast_q, tlast_nxt;
  logic [15:0]            word_cnt_nxt;
  logic [31:0]            sample_cnt_nxt;
  logic                   tag_err_nxt;
  logic                   accept, is_la, consume;
  logic                   unused_strobes;

  assign unused_strobes = ^{s_tstrb, s_tkeep};

  // s_tready deliberately has no dependence on s_tvalid
  assign s_tready = la_enable & ((state == IDLE) |
                                 ((state == EXPAND) & (rem == '0) & la_ready));
  assign accept   = s_tvalid & s_tready;
  assign is_la    = (s_tuser == pLA_TUSER);
  assign consume  = (state == EXPAND) & la_ready;
  assign la_valid = (state == EXPAND);
  assign la_last  = tlast_q & (rem == '0) & la_valid;

  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    data_nxt       = la_data;
    tlast_nxt      = tlast_q;
    word_cnt_nxt   = word_cnt;
    sample_cnt_nxt = sample_cnt;
    tag_err_nxt    = 1'b0;

    if (consume) begin
      sample_cnt_nxt = sample_cnt + 32'd1;
      if (rem != '0) rem_nxt = rem - pCNT_WIDTH'(1);
      else           state_nxt = IDLE;
    end

    // A new word can only arrive from IDLE or on the final-sample handshake,
    // so it safely overrides the return to IDLE above.
    if (accept) begin
      if (is_la) begin
        state_nxt    = EXPAND;
        data_nxt     = s_tdata[pLA_WIDTH-1:0];
        rem_nxt      = s_tdata[pDATA_WIDTH-1:pLA_WIDTH];
        tlast_nxt    = s_tlast;
        word_cnt_nxt = word_cnt + 16'd1;
      end else begin
        tag_err_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state      <= IDLE;
      rem        <= '0;
      la_data    <= '0;
      tlast_q    <= 1'b0;
      word_cnt   <= '0;
      sample_cnt <= '0;
      tag_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      la_data    <= data_nxt;
      tlast_q    <= tlast_nxt;
      word_cnt   <= word_cnt_nxt;
      sample_cnt <= sample_cnt_nxt;
      tag_err    <= tag_err_nxt;
    end
  end

endmodule

// File: tb/tb_la_stream_decoder.sv
// Self-checking bench for la_stream_decoder: directed scenarios plus random traffic
// against a queue-of-pending-samples reference model.
module tb_la_stream_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        la_enable = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = 4'hF;
  logic [3:0]  s_tkeep = 4'hF;
  logic        s_tlast = 1'b0;
  logic [1:0]  s_tuser = 2'b10;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [23:0] la_data;
  logic        la_last;
  logic        la_valid;
  logic        la_ready = 1'b0;
  logic [15:0] word_cnt;
  logic [31:0] sample_cnt;
  logic        tag_err;

  la_stream_decoder dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .la_enable(la_enable),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .la_data(la_data), .la_last(la_last), .la_valid(la_valid), .la_ready(la_ready),
    .word_cnt(word_cnt), .sample_cnt(sample_cnt), .tag_err(tag_err)
  );

  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every sample still owed to the consumer, in order.
  logic [23:0] q_data[$];
  bit          q_last[$];
  logic [15:0] m_wcnt = '0;
  logic [31:0] m_scnt = '0;
  logic        m_tag  = 1'b0;
  bit          m_acc, m_cons;

  logic        e_ready, e_valid, e_last;
  logic [23:0] e_data;
  logic        o_ready, o_valid, o_last;
  logic [23:0] o_data;
  logic [15:0] r_wcnt;
  logic [31:0] r_scnt;
  logic        r_tag;

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    int reps;
    #1;
    o_ready = s_tready; o_valid = la_valid; o_last = la_last; o_data = la_data;
    e_valid = (q_data.size() > 0);
    e_ready = la_enable && (q_data.size() == 0 || (q_data.size() == 1 && la_ready));
    e_data  = e_valid ? q_data[0] : 24'h0;
    e_last  = e_valid ? q_last[0] : 1'b0;
    m_cons  = e_valid && la_ready;
    m_acc   = s_tvalid && e_ready;
    if (axis_rst) begin
      q_data.delete(); q_last.delete();
      m_wcnt = '0; m_scnt = '0; m_tag = 1'b0;
    end else begin
      if (m_cons) begin
        void'(q_data.pop_front()); void'(q_last.pop_front());
        m_scnt = m_scnt + 32'd1;
      end
      m_tag = 1'b0;
      if (m_acc) begin
        if (s_tuser == 2'b10) begin
          reps = int'(s_tdata[31:24]) + 1;
          for (int k = 0; k < reps; k++) begin
            q_data.push_back(s_tdata[23:0]);
            q_last.push_back(s_tlast && (k == reps - 1));
          end
          m_wcnt = m_wcnt + 16'd1;
        end else begin
          m_tag = 1'b1;
        end
      end
    end
    @(posedge axis_clk); #1;
    r_wcnt = word_cnt; r_scnt = sample_cnt; r_tag = tag_err;
    @(negedge axis_clk);
  endtask

  task automatic test_reset();
    axis_rst = 1'b1; la_enable = 1'b0; s_tvalid = 1'b0; la_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({o_ready, o_valid, o_last, o_data} !== {e_ready, e_valid, e_last, 24'h0}) begin
      n_fail++; $display("FAIL reset outputs: got rdy/vld/last/data %b%b%b %h want %b%b%b 000000",
                         o_ready, o_valid, o_last, o_data, e_ready, e_valid, e_last);
    end
    n_checks++;
    if ({r_wcnt, r_scnt, r_tag} !== {16'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset counters: got %h %h %b want 0 0 0", r_wcnt, r_scnt, r_tag);
    end
    axis_rst = 1'b0;
  endtask

  task automatic test_single();
    int nsamp = 0;
    la_enable = 1'b1; la_ready = 1'b1;
    s_tdata = 32'h03_123456; s_tuser = 2'b10; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (m_acc) s_tvalid = 1'b0;
      if (o_valid) nsamp++;
      n_checks++;
      if ({o_ready, o_valid, o_last} !== {e_ready, e_valid, e_last}) begin
        n_fail++; $display("FAIL single ctrl c%0d: got %b%b%b want %b%b%b", c, o_ready, o_valid, o_last, e_ready, e_valid, e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL single data c%0d: got %h want %h", c, o_data, e_data); end
      end
      n_checks++;
      if ({r_wcnt, r_scnt, r_tag} !== {m_wcnt, m_scnt, m_tag}) begin
        n_fail++; $display("FAIL single cnt c%0d: got %h %h %b want %h %h %b", c, r_wcnt, r_scnt, r_tag, m_wcnt, m_scnt, m_tag);
      end
    end
    n_checks++;
    if (nsamp != 4 || r_wcnt !== 16'd1 || r_scnt !== 32'd4) begin
      n_fail++; $display("FAIL single totals: got samples %0d words %0d cnt %0d want 4 1 4", nsamp, r_wcnt, r_scnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3] = '{32'h00_000001, 32'h00_000002, 32'h01_000003};
    int idx = 0;
    la_ready = 1'b1; s_tuser = 2'b10; s_tlast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s_tvalid = (idx < 3);
      s_tdata  = (idx < 3) ? words[idx] : 32'h0;
      step();
      if (m_acc) idx++;
      n_checks++;
      if ({o_ready, o_valid, o_last} !== {e_ready, e_valid, e_last}) begin
        n_fail++; $display("FAIL b2b ctrl c%0d: got %b%b%b want %b%b%b", c, o_ready, o_valid, o_last, e_ready, e_valid, e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL b2b data c%0d: got %h want %h", c, o_data, e_data); end
      end
      n_checks++;
      if ({r_wcnt, r_scnt} !== {m_wcnt, m_scnt}) begin
        n_fail++; $display("FAIL b2b cnt c%0d: got %h %h want %h %h", c, r_wcnt, r_scnt, m_wcnt, m_scnt);
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_stall();
    bit rdy_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    s_tdata = 32'h02_ABCDEF; s_tuser = 2'b10; s_tvalid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      la_ready = (c < 6) ? rdy_pat[c] : 1'b1;
      step();
      if (m_acc) s_tvalid = 1'b0;
      n_checks++;
      if ({o_ready, o_valid, o_last} !== {e_ready, e_valid, e_last}) begin
        n_fail++; $display("FAIL stall ctrl c%0d: got %b%b%b want %b%b%b", c, o_ready, o_valid, o_last, e_ready, e_valid, e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL stall data c%0d: got %h want %h", c, o_data, e_data); end
      end
      n_checks++;
      if (r_scnt !== m_scnt) begin n_fail++; $display("FAIL stall scnt c%0d: got %h want %h", c, r_scnt, m_scnt); end
    end
  endtask

  task automatic test_tag();
    int errs = 0;
    logic [15:0] w0 = m_wcnt;
    la_ready = 1'b1;
    s_tdata = 32'h00_BADBAD; s_tuser = 2'b01; s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (r_tag) errs++;
      if (m_acc && s_tuser == 2'b01) begin s_tdata = 32'h00_111111; s_tuser = 2'b10; end
      else if (m_acc) s_tvalid = 1'b0;
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data || e_data !== 24'h111111) begin
          n_fail++; $display("FAIL tag data c%0d: got %h want %h", c, o_data, e_data);
        end
      end
      n_checks++;
      if ({r_tag, r_wcnt, o_valid} !== {m_tag, m_wcnt, e_valid}) begin
        n_fail++; $display("FAIL tag state c%0d: got %b %h %b want %b %h %b", c, r_tag, r_wcnt, o_valid, m_tag, m_wcnt, e_valid);
      end
    end
    n_checks++;
    if (errs != 1 || r_wcnt !== w0 + 16'd1) begin
      n_fail++; $display("FAIL tag totals: got pulses %0d words %h want 1 %h", errs, r_wcnt, w0 + 16'd1);
    end
  endtask

  task automatic test_last_enable();
    la_ready = 1'b1; la_enable = 1'b1;
    s_tdata = 32'h01_00FFFF; s_tuser = 2'b10; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        la_enable = 1'b0; s_tdata = 32'h00_222222; s_tlast = 1'b0;
      end
      step();
      n_checks++;
      if ({o_ready, o_valid, o_last} !== {e_ready, e_valid, e_last}) begin
        n_fail++; $display("FAIL last ctrl c%0d: got %b%b%b want %b%b%b", c, o_ready, o_valid, o_last, e_ready, e_valid, e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL last data c%0d: got %h want %h", c, o_data, e_data); end
      end
    end
    s_tvalid = 1'b0; la_enable = 1'b1;
  endtask

  task automatic test_max_and_reset();
    int nsamp = 0;
    la_ready = 1'b1; s_tlast = 1'b0; s_tuser = 2'b10;
    s_tdata = 32'hFF_ABCDEF; s_tvalid = 1'b1;
    for (int c = 0; c < 259; c++) begin
      step();
      if (m_acc) s_tvalid = 1'b0;
      if (o_valid) nsamp++;
      if (e_valid && o_data !== e_data) begin
        n_checks++; n_fail++; $display("FAIL max data c%0d: got %h want %h", c, o_data, e_data);
      end
    end
    n_checks++;
    if (nsamp != 256 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL max count: got %0d samples, valid %b want 256 0", nsamp, o_valid);
    end
    s_tdata = 32'hFF_5A5A5A; s_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      axis_rst = (c == 6);
      if (c == 7) la_enable = 1'b0;
      step();
      if (m_acc) s_tvalid = 1'b0;
      n_checks++;
      if ({o_valid, o_last, r_wcnt, r_scnt} !== {e_valid, e_last, m_wcnt, m_scnt}) begin
        n_fail++; $display("FAIL rstmid c%0d: got %b%b %h %h want %b%b %h %h", c, o_valid, o_last, r_wcnt, r_scnt, e_valid, e_last, m_wcnt, m_scnt);
      end
    end
    n_checks++;
    if ({o_valid, r_wcnt, r_scnt} !== {1'b0, 16'h0, 32'h0}) begin
      n_fail++; $display("FAIL rstmid final: got %b %h %h want 0 0 0", o_valid, r_wcnt, r_scnt);
    end
    axis_rst = 1'b0; la_enable = 1'b1;
  endtask

  task automatic test_random();
    bit pend = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        s_tdata  = {($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 40)) : 8'($urandom_range(0, 3)), 24'($urandom)};
        s_tuser  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
        s_tlast  = 1'($urandom_range(0, 1));
        s_tvalid = ($urandom_range(0, 9) < 6);
        pend     = s_tvalid;
      end
      la_ready  = ($urandom_range(0, 9) < 7);
      la_enable = ($urandom_range(0, 19) != 0);
      step();
      if (m_acc) begin pend = 1'b0; s_tvalid = 1'b0; end
      n_checks++;
      if ({o_ready, o_valid, o_last} !== {e_ready, e_valid, e_last}) begin
        n_fail++; $display("FAIL rand ctrl c%0d: got %b%b%b want %b%b%b", c, o_ready, o_valid, o_last, e_ready, e_valid, e_last);
      end
      if (e_valid) begin
        n_checks++;
        if (o_data !== e_data) begin n_fail++; $display("FAIL rand data c%0d: got %h want %h", c, o_data, e_data); end
      end
      n_checks++;
      if ({r_wcnt, r_scnt, r_tag} !== {m_wcnt, m_scnt, m_tag}) begin
        n_fail++; $display("FAIL rand cnt c%0d: got %h %h %b want %h %h %b", c, r_wcnt, r_scnt, r_tag, m_wcnt, m_scnt, m_tag);
      end
    end
  endtask

  initial begin
    @(negedge axis_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_tag();
    test_last_enable();
    test_max_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
